scadere_seriala: RTL and testbench
==================================

// Module: scadere_seriala
// PURPOSE
//  Bit-serial W-bit subtractor: the inverse operation of the parallel adder
//  (aduna). It computes d = x - y mod 2^W and a borrow flag, processing one bit
//  per clock, LSB first. The block sits beside aduna in the arithmetic datapath.
//  Loop-back property: aduna(d, y) returns s == x and c4 == b_out.
// PARAMETERS
//  W  4  operand / result width in bits (W >= 2)
// PORTS
//  clk    in   1  single clock; all state updates on the rising edge
//  rst_n  in   1  reset, asynchronous, active-low
//  start  in   1  request; sampled only in IDLE
//  x      in   W  minuend; captured on an accepted start
//  y      in   W  subtrahend; captured on an accepted start
//  busy   out  1  high while in SHIFT or DONE
//  done   out  1  one-cycle pulse; d and b_out are valid from this cycle
//  d      out  W  difference x - y mod 2^W
//  b_out  out  1  final borrow; 1 iff x < y (unsigned)
// BEHAVIOUR
//  Reset
//   - rst_n low clears everything immediately, independent of clk:
//     state=IDLE, busy=0, done=0, d=0, b_out=0, count=0, borrow=0, shift regs=0.
//   - Reset mid-operation abandons the operation. No done pulse is produced.
//  FSM states: IDLE, SHIFT, DONE (2-bit encoding)
//   - IDLE -> SHIFT when start=1.
//     On that edge: xs<=x, ys<=y, borrow<=0, count<=0.
//   - SHIFT, each edge:
//     a=xs[0], b=ys[0];
//     diff = a ^ b ^ borrow;
//     borrow <= (~a & b) | (~(a ^ b) & borrow);
//     ds <= {diff, ds[W-1:1]}; xs, ys shift right by 1; count++.
//     Leave for DONE on the edge where count == W-1 (exactly W SHIFT cycles).
//   - DONE -> IDLE unconditionally after 1 cycle.
//     In DONE: done=1, d=ds, b_out=borrow.
//  Latency: start sampled at edge k -> done high during the cycle after edge k+W.
//   Throughput is one result per W+2 cycles.
//  Outputs
//   - d and b_out are registered. They hold their value from DONE until the
//     next DONE or reset; they are not cleared by a new start.
//   - busy is high in SHIFT and DONE.
//  Boundaries
//   - start while busy: ignored, with no effect on the operation in flight.
//   - start held high: a new operation is accepted on the first IDLE cycle.
//   - x and y changing during SHIFT: no effect (captured copies are used).
//   - Wrap-around: y > x yields d = x - y + 2^W with b_out = 1.
//   - x == y yields d = 0 with b_out = 0.
//   - count width is clog2(W). It never exceeds W-1.
// STRUCTURE
//  - Shared include scadere_defs.vh holds:
//    state localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2; default width W=4.
//  - Sub-module scadator_bit: combinational 1-bit full subtractor
//    (a, b, bin -> diff, bout), instantiated once in the SHIFT datapath.
//  - Top level holds the FSM, counter, shift registers and output registers.
// TESTING (W=4; every check also loops d,y back through aduna: s==x, c4==b_out)
//  - x=1001, y=0000, start 1 cycle -> done after 5 edges, d=1001, b_out=0.
//  - x=0000, y=0001 -> d=1111, b_out=1 (wrap-around).
//  - x=0101, y=0101 -> d=0000, b_out=0; busy high for exactly 5 cycles.
//  - x=1001, y=0011 -> d=0110, b_out=0; then pulse start=1 with x=1111
//    during SHIFT -> ignored, d stays 0110.
//  - Start x=1100, y=0001, assert rst_n=0 at the 2nd SHIFT cycle ->
//    outputs 0 at once, no done pulse; a fresh op 1100-0001 gives d=1011.
//  - Exhaustive: all 256 (x, y) pairs back-to-back with start held high ->
//    each d == (x-y)&4'hF, b_out == (x<y).

Source files
------------

// File: rtl/scadere_seriala_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package scadere_seriala_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit count of a counter that must reach w-1; a 1-bit floor keeps w=1 legal.
    function automatic int count_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/scadere_seriala_bit.sv
// One-bit full subtractor: diff = a - b - bin, with the borrow passed on in bout.
module scadator_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/scadere_seriala.sv
// Bit-serial W-bit subtractor d = x - y mod 2^W, LSB first, one bit per clock.
// The final borrow b_out is 1 exactly when x < y.
module scadere_seriala
    import scadere_seriala_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         b_out
);

    localparam int CW = count_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state_q, state_d;
    logic [W-1:0]   xs_q, xs_d;
    logic [W-1:0]   ys_q, ys_d;
    logic [W-1:0]   ds_q, ds_d;
    logic [CW-1:0]  count_q, count_d;
    logic           borrow_q, borrow_d;
    logic [W-1:0]   res_q, res_d;
    logic           b_out_q, b_out_d;

    logic           bit_diff;
    logic           bit_bout;

    scadator_bit u_bit (
        .a    (xs_q[0]),
        .b    (ys_q[0]),
        .bin  (borrow_q),
        .diff (bit_diff),
        .bout (bit_bout)
    );

    always_comb begin
        state_d  = state_q;
        xs_d     = xs_q;
        ys_d     = ys_q;
        ds_d     = ds_q;
        count_d  = count_q;
        borrow_d = borrow_q;
        res_d    = res_q;
        b_out_d  = b_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SHIFT;
                    xs_d     = x;
                    ys_d     = y;
                    borrow_d = 1'b0;
                    count_d  = '0;
                end
            end
            S_SHIFT: begin
                borrow_d = bit_bout;
                ds_d     = {bit_diff, ds_q[W-1:1]};
                xs_d     = xs_q >> 1;
                ys_d     = ys_q >> 1;
                count_d  = count_q + CW'(1);
                // Results are latched on the last shift edge so they are already
                // valid while done is high; the counter is parked at zero.
                if (count_q == LAST) begin
                    state_d = S_DONE;
                    count_d = '0;
                    res_d   = {bit_diff, ds_q[W-1:1]};
                    b_out_d = bit_bout;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            xs_q     <= '0;
            ys_q     <= '0;
            ds_q     <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            res_q    <= '0;
            b_out_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            xs_q     <= xs_d;
            ys_q     <= ys_d;
            ds_q     <= ds_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            res_q    <= res_d;
            b_out_q  <= b_out_d;
        end
    end

    assign busy  = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done  = (state_q == S_DONE);
    assign d     = res_q;
    assign b_out = b_out_q;

endmodule

// File: tb/tb_scadere_seriala.sv
// Self-checking bench for scadere_seriala (W=4): directed cases, exhaustive sweep
// with start held high, and randomized traffic against a cycle-level reference.
module tb_scadere_seriala;

    localparam int W   = 4;
    localparam int MOD = 2 ** W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;

    int check_count = 0;
    int pass_count  = 0;
    bit check_en    = 0;

    // Reference: age counts edges since the operation was accepted (-1 = idle).
    int age   = -1;
    int cap_x = 0;
    int cap_y = 0;
    int exp_d = 0;
    int exp_b = 0;

    scadere_seriala #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) pass_count++;
        else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age   <= -1;
            exp_d <= 0;
            exp_b <= 0;
        end else if (age < 0) begin
            if (start) begin
                age   <= 0;
                cap_x <= int'(x);
                cap_y <= int'(y);
            end
        end else if (age == W) begin
            age <= -1;
        end else begin
            age <= age + 1;
            if (age == W - 1) begin
                exp_d <= (cap_x - cap_y + MOD) % MOD;
                exp_b <= (cap_x < cap_y) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        int sum;
        if (check_en) begin
            checkOutput("busy",  int'(busy),  (age >= 0) ? 1 : 0);
            checkOutput("done",  int'(done),  (age == W) ? 1 : 0);
            checkOutput("d",     int'(d),     exp_d);
            checkOutput("b_out", int'(b_out), exp_b);
            if (age == W) begin
                sum = int'(d) + cap_y;
                checkOutput("loop_s",  sum % MOD, cap_x);
                checkOutput("loop_c4", sum / MOD, int'(b_out));
            end
        end
    end

    // Launches one op with a single-cycle start; x/y are scrambled while it runs.
    task automatic applyStimulus(input logic [W-1:0] xa, input logic [W-1:0] ya,
                                 input int glitch_at, output int latency,
                                 output int busy_cycles);
        @(negedge clk);
        x = xa;
        y = ya;
        start = 1'b1;
        latency = -1;
        busy_cycles = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            x = W'($urandom);
            y = W'($urandom);
            start = 1'b0;
            if (i == glitch_at) begin
                start = 1'b1;
                x = '1;
            end
            if (busy) busy_cycles++;
            if (done && latency < 0) latency = i;
            if (!busy && busy_cycles > 0) break;
        end
        start = 1'b0;
        if (latency < 0) checkOutput("op_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int bc;
        int waited;
        int done_seen;
        logic [W-1:0] xa;
        logic [W-1:0] ya;

        rst_n = 1'b0;
        start = 1'b0;
        x = '0;
        y = '0;
        #12;
        checkOutput("rst_busy",  int'(busy),  0);
        checkOutput("rst_done",  int'(done),  0);
        checkOutput("rst_d",     int'(d),     0);
        checkOutput("rst_b_out", int'(b_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_en = 1;

        applyStimulus(4'b1001, 4'b0000, 0, lat, bc);
        checkOutput("t1_latency", lat, 5);
        checkOutput("t1_d", int'(d), 9);
        checkOutput("t1_b", int'(b_out), 0);

        applyStimulus(4'b0000, 4'b0001, 0, lat, bc);
        checkOutput("t2_d", int'(d), 15);
        checkOutput("t2_b", int'(b_out), 1);

        applyStimulus(4'b0101, 4'b0101, 0, lat, bc);
        checkOutput("t3_d", int'(d), 0);
        checkOutput("t3_b", int'(b_out), 0);
        checkOutput("t3_busy_cycles", bc, 5);

        applyStimulus(4'b1001, 4'b0011, 2, lat, bc);
        checkOutput("t4_d", int'(d), 6);
        checkOutput("t4_b", int'(b_out), 0);
        repeat (3) @(negedge clk);
        checkOutput("t4_d_hold", int'(d), 6);
        checkOutput("t4_busy_idle", int'(busy), 0);

        // Reset in the second shift cycle must clear outputs without clocking.
        @(negedge clk);
        x = 4'b1100;
        y = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_done", int'(done), 0);
        checkOutput("t5_rst_d", int'(d), 0);
        checkOutput("t5_rst_b", int'(b_out), 0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("t5_no_done", done_seen, 0);
        applyStimulus(4'b1100, 4'b0001, 0, lat, bc);
        checkOutput("t5_d", int'(d), 11);
        checkOutput("t5_b", int'(b_out), 0);

        // Exhaustive sweep, start held high: one result every W+2 cycles.
        @(negedge clk);
        start = 1'b1;
        for (int p = 0; p < MOD * MOD; p++) begin
            xa = W'(p / MOD);
            ya = W'(p % MOD);
            x = xa;
            y = ya;
            waited = 0;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                waited = i;
                if (done) break;
            end
            if (!done) begin
                checkOutput("exh_timeout", 0, 1);
                break;
            end
            checkOutput("exh_period", waited, (p == 0) ? W + 1 : W + 2);
            checkOutput("exh_d", int'(d), (int'(xa) - int'(ya) + MOD) % MOD);
            checkOutput("exh_b", int'(b_out), (xa < ya) ? 1 : 0);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            x = W'($urandom);
            y = W'($urandom);
            #1 rst_n = ($urandom_range(0, 149) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        #1 rst_n = 1'b1;
        repeat (10) @(negedge clk);

        check_en = 0;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
